uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_bit_timer.sv | 23 ++
 rtl/uart_tx.sv | 119 +++++++++++
 tb/tb_uart_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame constants shared by the UART transmit and receive sides
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_DELAY_COUNTS = 5210;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts clk cycles within one bit time; bit_end marks the last cycle of the bit
module uart_tx_bit_timer import uart_pkg::*; #(
    parameter int DELAY_COUNTS = DEFAULT_DELAY_COUNTS
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (DELAY_COUNTS > 1) ? $clog2(DELAY_COUNTS) : 1;

    logic [CW-1:0] r_count;

    assign bit_end = (r_count == CW'(DELAY_COUNTS - 1));

    // Count 0..DELAY_COUNTS-1, wrapping at each bit boundary and held at zero while cleared
    always_ff @(posedge clk) begin
        if (rst || clear || bit_end) r_count <= '0;
        else                         r_count <= r_count + CW'(1);
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter; define UART_TX_PARITY_EN to add a parity bit (8E1/8O1)
module uart_tx import uart_pkg::*; #(
    parameter int DELAY_COUNTS = DEFAULT_DELAY_COUNTS,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done
);

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_idx;
    logic                 r_tx;
    logic                 r_tx_ready;
    logic                 w_bit_end;
    logic                 w_clear;
    logic                 w_accept;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    assign w_accept = tx_valid && r_tx_ready;
    assign w_clear  = (r_state == ST_IDLE);
    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign tx_done  = (r_state == ST_STOP) && w_bit_end;

    uart_tx_bit_timer #(
        .DELAY_COUNTS(DELAY_COUNTS)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .bit_end(w_bit_end)
    );

    // Parity selector is a 0/1 flag; it only changes the line when the parity bit is compiled in
    always_ff @(posedge clk) begin
        assert (PARITY_ODD == 0 || PARITY_ODD == 1);
    end

    // Frame sequencer: latch the byte, walk START/DATA/(PARITY)/STOP, drive the line from a register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_START;
                        r_shift    <= tx_data;
                        r_tx       <= 1'b0;
                        r_tx_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= parity_of(tx_data, PARITY_ODD != 0);
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= ST_PARITY;
                            r_tx      <= r_parity;
`else
                            r_state   <= ST_STOP;
                            r_tx      <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_state    <= ST_IDLE;
                        r_tx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx, even and odd parity instances at DELAY_COUNTS=4
module tb_uart_tx;

    localparam int D  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * D;

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
    } frame_vec_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = '0;
    logic [1:0] w_ready;
    logic [1:0] w_tx;
    logic [1:0] w_done;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          m_pos  = -1;
    logic [10:0] m_frame [2];
    frame_vec_t  vecs [13];

    always #5 clk = ~clk;

    uart_tx #(.DELAY_COUNTS(D), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(w_ready[0]), .tx(w_tx[0]), .tx_done(w_done[0])
    );

    uart_tx #(.DELAY_COUNTS(D), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(w_ready[1]), .tx(w_tx[1]), .tx_done(w_done[1])
    );

    // Line levels of one frame, bit 0 first: start, data LSB first, optional parity, stop
    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic odd);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = (^d) ^ odd;
`endif
        return f;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    // One clock: advance the frame-position model with the inputs seen at the edge, then compare
    task automatic tick();
        @(posedge clk);
        if (rst) m_pos = -1;
        else if (m_pos < 0) begin
            if (tx_valid) begin
                m_pos      = 0;
                m_frame[0] = frame_of(tx_data, 1'b0);
                m_frame[1] = frame_of(tx_data, 1'b1);
            end
        end else m_pos = (m_pos == FL - 1) ? -1 : m_pos + 1;
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            chk("tx",    k, w_tx[k],    (m_pos < 0) ? 1'b1 : m_frame[k][m_pos / D]);
            chk("ready", k, w_ready[k], m_pos < 0);
            chk("done",  k, w_done[k],  m_pos == FL - 1);
        end
    endtask

    // Send one byte from idle, scramble tx_data/tx_valid mid-frame, decode the line at mid-bit
    task automatic send_frame(input frame_vec_t v);
        logic [10:0] cap [2];
        int          done_cnt [2];
        int          done_at [2];
        tx_valid = 1'b1;
        tx_data  = v.data;
        tick();
        for (int k = 0; k < 2; k++) begin
            cap[k]      = '1;
            done_cnt[k] = 0;
            done_at[k]  = -1;
        end
        for (int p = 0; p < FL; p++) begin
            if (p > 0) tick();
            for (int k = 0; k < 2; k++) begin
                if (p % D == D / 2) cap[k][p / D] = w_tx[k];
                if (w_done[k]) begin
                    done_cnt[k]++;
                    done_at[k] = p + 1;
                end
            end
            tx_valid = ($urandom_range(3) == 0);
            tx_data  = 8'($urandom);
        end
        tx_valid = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("byte",     k, cap[k][8:1], v.data);
            chk("start",    k, cap[k][0], 1'b0);
            chk("stop",     k, cap[k][NB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
            chk("parity",   k, cap[k][9], (k == 1) ? v.par_odd : v.par_even);
`endif
            chk("done_cnt", k, done_cnt[k], 1);
            chk("done_at",  k, done_at[k], FL);
        end
    endtask

    initial begin
        int idle_cnt;
        int done_seen;
        vecs = '{
            '{8'h55, 1'b0, 1'b1}, '{8'h07, 1'b1, 1'b0}, '{8'hF0, 1'b0, 1'b1},
            '{8'h00, 1'b0, 1'b1}, '{8'hFF, 1'b0, 1'b1}, '{8'h01, 1'b1, 1'b0},
            '{8'h80, 1'b1, 1'b0}, '{8'h7F, 1'b1, 1'b0}, '{8'hA5, 1'b0, 1'b1},
            '{8'h3C, 1'b0, 1'b1}, '{8'h41, 1'b0, 1'b1}, '{8'h6B, 1'b1, 1'b0},
            '{8'h81, 1'b0, 1'b1}
        };

        // Reset wins over a simultaneous request
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        repeat (3) tick();
        rst      = 1'b0;
        tx_valid = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) send_frame(vecs[i]);

        // Back-to-back with tx_valid held: exactly one ready cycle between frames
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_data  = 8'h3C;
        idle_cnt = 0;
        for (int n = 0; n < FL + 1; n++) begin
            tick();
            if (w_ready[0]) idle_cnt++;
        end
        chk("b2b_idle",  0, idle_cnt, 1);
        chk("b2b_start", 0, w_tx[0], 1'b0);
        tx_valid = 1'b0;
        repeat (FL) tick();

        // Reset in the middle of data bit 3 abandons the frame without a done pulse
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        tx_valid = 1'b0;
        repeat (4 * D + 1) tick();
        rst = 1'b1;
        tick();
        chk("rst_tx",    0, w_tx[0], 1'b1);
        chk("rst_ready", 0, w_ready[0], 1'b1);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < FL; n++) begin
            tick();
            if (w_done[0] || w_done[1]) done_seen++;
        end
        chk("rst_no_done", 0, done_seen, 0);
        send_frame(vecs[12]);

        // Random traffic with occasional resets against the frame-position model
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(199) == 0);
            tx_valid = ($urandom_range(2) == 0);
            tx_data  = 8'($urandom);
            tick();
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        repeat (FL + 2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
